// File: rtl/key_conditioner.sv
// key_conditioner: per-button two-flop synchronizer, counter debouncer and
// single-cycle press pulse generator feeding the tug-of-war game core.
module key_conditioner #(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic              freeze,
    output logic [N_KEYS-1:0] held,
    output logic [N_KEYS-1:0] press
);

    // Counter needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] key_norm_c;
    logic [N_KEYS-1:0] s1;
    logic [N_KEYS-1:0] s2;
    logic [N_KEYS-1:0] stable_q;
    logic [N_KEYS-1:0] stable_d;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] press_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];

    // Normalise polarity so that 1 always means pressed.
    assign key_norm_c = key_raw ^ {N_KEYS{ACTIVE_LOW}};

    // Two-flop synchronizer for the asynchronous button levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= key_norm_c;
            s2 <= s1;
        end
    end

    // Debounce decision: count consecutive disagreements, accept at the limit.
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (s2[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2[i];
                    press_d[i]  = s2[i] & ~freeze;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= '0;
            press_q  <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign held  = stable_q;
    assign press = press_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected press pulses
// (cycle, value); a negedge monitor pops and checks every nonzero press.
module tb_key_conditioner;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  val;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [1:0] key_raw;
    logic       freeze;
    logic [1:0] held;
    logic [1:0] press;

    int unsigned cyc;
    int          total;
    int          bad;
    exp_t        exp_q[$];

    key_conditioner #(
        .N_KEYS          (2),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .key_raw (key_raw),
        .freeze  (freeze),
        .held    (held),
        .press   (press)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Rising-edge counter; edge k makes cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every nonzero press must match the head of the expectation queue.
    always @(negedge clk) begin
        if (press != 2'b00) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL press_unexpected: cyc=%0d press=%b required none", cyc, press);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.val != press) begin
                    bad++;
                    $display("FAIL press_event: got cyc=%0d press=%b required cyc=%0d press=%b",
                             cyc, press, e.cyc, e.val);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b required %b (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_press(input int unsigned at, input logic [1:0] v);
        exp_t e;
        e.cyc = at;
        e.val = v;
        exp_q.push_back(e);
    endtask

    initial begin
        cyc     = 0;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        key_raw = 2'b00;
        freeze  = 1'b0;

        // Reset with both keys pressed: outputs clear before any clock edge.
        #10;
        check2("reset_held_noclk", held, 2'b00);
        check2("reset_press_noclk", press, 2'b00);
        tick(3);
        check2("reset_held_clocked", held, 2'b00);
        key_raw = 2'b11;
        tick(1);
        reset_n = 1'b1;
        tick(4);
        check2("idle_held", held, 2'b00);

        // Clean press on key 0: held and press rise after E5.
        key_raw = 2'b10;
        expect_press(cyc + 6, 2'b01);
        tick(5);
        check2("clean_held_e4", held, 2'b00);
        tick(1);
        check2("clean_held_e5", held, 2'b01);
        tick(4);
        check2("clean_held_hold", held, 2'b01);

        // Release: held falls after the same latency, no pulse.
        key_raw = 2'b11;
        tick(5);
        check2("release_held_e4", held, 2'b01);
        tick(1);
        check2("release_held_e5", held, 2'b00);
        tick(3);

        // Bounce on key 1: one-cycle disagreements are discarded.
        for (int i = 0; i < 12; i++) begin
            key_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
            if (i == 7) check2("bounce_held_mid", held, 2'b00);
        end
        key_raw[1] = 1'b1;
        tick(8);
        check2("bounce_held_end", held, 2'b00);

        // Simultaneous presses pulse together; release gives no pulse.
        key_raw = 2'b00;
        expect_press(cyc + 6, 2'b11);
        tick(5);
        check2("simul_held_e4", held, 2'b00);
        tick(1);
        check2("simul_held_e5", held, 2'b11);
        tick(4);
        key_raw = 2'b11;
        tick(5);
        check2("simul_rel_e4", held, 2'b11);
        tick(1);
        check2("simul_rel_e5", held, 2'b00);
        tick(3);

        // Freeze: held updates, pulse is lost rather than deferred.
        freeze  = 1'b1;
        key_raw = 2'b10;
        tick(6);
        check2("freeze_held", held, 2'b01);
        check2("freeze_press", press, 2'b00);
        freeze = 1'b0;
        tick(5);
        check2("unfreeze_held", held, 2'b01);
        key_raw = 2'b11;
        tick(8);
        check2("freeze_rel_held", held, 2'b00);
        key_raw = 2'b10;
        expect_press(cyc + 6, 2'b01);
        tick(8);
        check2("repress_held", held, 2'b01);
        key_raw = 2'b11;
        tick(8);
        check2("repress_rel_held", held, 2'b00);

        // Reset mid-debounce spanning E3; held key is a fresh press afterwards.
        key_raw = 2'b10;
        tick(3);
        reset_n = 1'b0;
        tick(1);
        check2("midrst_held", held, 2'b00);
        check2("midrst_press", press, 2'b00);
        reset_n = 1'b1;
        expect_press(cyc + 6, 2'b01);
        tick(5);
        check2("midrst_held_e4", held, 2'b00);
        tick(1);
        check2("midrst_held_e5", held, 2'b01);
        tick(6);

        // Every queued pulse must have been observed.
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_presses: got %0d outstanding required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage between the raw DE1-SoC push-buttons and the tug-of-war game core. It synchronizes and debounces each button, then emits a one-cycle `press` pulse per accepted press, so a held button counts once. It also provides a debounced level per button. The `press` outputs drive the game core's player inputs; the core's game-over condition drives `freeze`.

## Interface
Parameters:
- `N_KEYS`, 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, 4: consecutive disagreeing cycles required to accept a level change.
  - Legal range is ≥1.
  - Board builds use 500000 (10 ms at 50 MHz).
- `ACTIVE_LOW`, 1: when 1, `key_raw` low means pressed; when 0, high means pressed.

Ports:
- `clk`, in, 1: system clock; all state updates on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `key_raw`, in, `N_KEYS`: asynchronous button levels; bit i is channel i.
- `freeze`, in, 1: when 1, all `press` bits are forced 0. Debouncing continues.
- `held`, out, `N_KEYS`: debounced level per channel; 1 = pressed.
- `press`, out, `N_KEYS`: one-cycle pulse when a channel's debounced level goes released→pressed.

## Operation
Each channel is independent and holds the following state:
- Two-flop synchronizer `s1`→`s2`. Input is `key_raw[i]` XOR `ACTIVE_LOW`, so 1 = pressed after inversion.
- `stable` register; drives `held[i]`.
- Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)` (minimum 1 bit).
- Registered `press[i]`.

Update rule at each rising edge:
- If `s2 == stable`: `cnt <= 0`; `press[i] <= 0`.
- If `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`; `press[i] <= 0`.
- If `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`:
  - `stable <= s2`; `cnt <= 0`.
  - `press[i] <= s2 & ~freeze`, so it pulses on a press only, never on a release.

Behaviour that follows from this rule:
- A disagreement shorter than `DEBOUNCE_CYCLES` consecutive cycles is discarded (bounce or glitch). Any agreeing cycle clears `cnt`.
- Holding a button produces exactly one `press` pulse. Releasing produces none, and `held` drops after the same debounce latency.
- A new pulse requires an accepted release followed by an accepted press.

Boundary conditions:
- **Simultaneous presses on several channels:** each channel pulses independently in the same cycle. Tie resolution is the game core's responsibility.
- **`freeze` high at the acceptance edge:** the pulse is lost, not deferred. `held` still updates.
- **`DEBOUNCE_CYCLES` = 1:** a change is accepted on the first disagreeing edge.
- **Counter range:** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.

Reset (`reset_n` = 0):
- Asynchronously clears `s1`, `s2`, `stable`, `cnt` and `press`, so `held` = 0 and `press` = 0.
- Applies mid-debounce as well; any partial count is discarded.
- A button still held when reset deasserts is treated as a fresh press. It yields one pulse after the normal latency.

## Timing
- Let E0 be the first rising edge that samples a pressed `key_raw`, with the button held steadily from E0.
  - `s2` = 1 after E1.
  - `held` and `press` both rise after edge E(1+`DEBOUNCE_CYCLES`). With the default of 4, this is E5.
  - `press` falls after the next edge, E(2+`DEBOUNCE_CYCLES`).
- Release follows the same latency: `held` falls after E(1+`DEBOUNCE_CYCLES`) relative to the first released sample.
- `press` is exactly one clock wide.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Minimum press-to-press spacing is 2×`DEBOUNCE_CYCLES` cycles plus synchronizer slack.

## Test plan
All scenarios use `N_KEYS`=2, `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW`=1, and a 100-unit clock period.

- **Reset:** hold `reset_n`=0 with both keys pressed (`key_raw`=2'b00) → `held`=0 and `press`=0 immediately, with no clock required.
- **Clean press:** release reset with `key_raw`=2'b11, then set `key_raw[0]`=0 and hold for 10 cycles → `press[0]`=1 for exactly one cycle after E5 and `held[0]`=1 from E5. Channel 1 stays 0.
- **Bounce:** toggle `key_raw[1]` 0/1 every cycle for 12 cycles, then hold it at 1 → `press[1]` and `held[1]` never assert.
- **Simultaneous presses and release:**
  - Set `key_raw`=2'b00 on the same edge and hold → `press`=2'b11 for one cycle.
  - Release both → `held` returns to 0 four cycles after `s2` changes, with no `press` pulse.
- **Freeze:** with `freeze`=1, press key 0 → `held[0]` rises and `press[0]` stays 0. Set `freeze`=0 while still held → still no pulse. Release, then press again → exactly one pulse.
- **Reset mid-operation:** assert `reset_n`=0 for one cycle at E3 of a press on key 0, keep the key held, then deassert → single `press[0]` pulse five edges after the first post-reset sampling edge.
